pipeline_stage_chain: RTL and testbench

- Parametrised replacement for the fixed per-stage resetable flip-flops between Fetch/Decode/Execute/Memory/WB.
- DEPTH-stage chain of WIDTH-bit registers; each stage carries a valid bit.
- Valid/ready handshake gives back-pressure; empty stages (bubbles) collapse.
- Per-stage flush mask lets control logic squash stages after a branch/PC redirect.

---
 rtl/pipeline_stage_chain_if.sv | 46 ++++
 rtl/pipeline_stage_chain.sv | 114 +++++++++++
 tb/tb_pipeline_stage_chain.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_chain_if.sv
// ----------------------------------------------------------------------------
// pipeline_stage_chain_if
//
// Purpose: bundles the upstream handshake, downstream handshake, flush
// control and status outputs of pipeline_stage_chain.
//
// Signals:
//   in_valid    upstream presents in_data
//   in_ready    stage 0 can accept this cycle
//   in_data     payload entering stage 0
//   out_valid   last stage holds a valid payload
//   out_ready   downstream accepts out_data this cycle
//   out_data    payload of the last stage
//   flush_mask  bit i = 1 squashes stage i at the next edge
//   stage_valid valid bit of every stage (bit 0 = entry stage)
//   occupancy   number of valid stages
//
// Modports:
//   slave  - the chain itself
//   master - the surrounding control/datapath that drives the chain
// ----------------------------------------------------------------------------
interface pipeline_stage_chain_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int COUNTW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [DEPTH-1:0]  flush_mask;
    logic [DEPTH-1:0]  stage_valid;
    logic [COUNTW-1:0] occupancy;

    modport slave (
        input  in_valid, in_data, out_ready, flush_mask,
        output in_ready, out_valid, out_data, stage_valid, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready, flush_mask,
        input  in_ready, out_valid, out_data, stage_valid, occupancy
    );
endinterface

// File: rtl/pipeline_stage_chain.sv
// ----------------------------------------------------------------------------
// pipeline_stage_chain
//
// Purpose: DEPTH-stage chain of WIDTH-bit registers with a valid bit per
// stage, valid/ready back-pressure, bubble collapsing and a per-stage flush
// mask. Drop-in replacement for fixed inter-stage flip-flops of an in-order
// pipeline.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; clears valid bits, data and occupancy
//   bus    pipeline_stage_chain_if.slave (handshakes, flush, status)
//
// Parameters:
//   WIDTH  payload bits per stage
//   DEPTH  number of stages (1..16)
//   COUNTW occupancy width, 2^COUNTW > DEPTH
// ----------------------------------------------------------------------------
module pipeline_stage_chain #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int COUNTW = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_stage_chain_if.slave  bus
);

    logic [DEPTH-1:0] validQ;
    logic [DEPTH-1:0] validD;
    logic [WIDTH-1:0] dataQ   [DEPTH];
    logic [WIDTH-1:0] srcData [DEPTH];
    logic [DEPTH-1:0] srcValid;
    logic [DEPTH-1:0] loadEn;
    logic [DEPTH-1:0] rdy;
    logic [COUNTW-1:0] occQ;

    function automatic logic [COUNTW-1:0] popCount(input logic [DEPTH-1:0] v);
        logic [COUNTW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + COUNTW'(v[i]);
        end
        return cnt;
    endfunction

    // Ready chain: a stage can take a word if it is empty or if everything
    // downstream of it can move. Built from the tail with a running term so
    // only registered valids and out_ready feed it (never in_valid, never
    // flush_mask).
    always_comb begin
        logic acc;
        acc = bus.out_ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc || !validQ[i];
            rdy[i] = acc;
        end
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        srcValid   = '0;
        srcValid[0] = bus.in_valid;
        srcData[0]  = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            srcValid[i] = validQ[i-1];
            srcData[i]  = dataQ[i-1];
        end
    end

    // Next valid: a ready stage takes whatever its source offers (which also
    // covers draining into a bubble); a stalled stage holds. Flush wins last,
    // after the handshake has already been decided from rdy.
    always_comb begin
        validD = validQ;
        loadEn = '0;
        for (int i = 0; i < DEPTH; i++) begin
            loadEn[i] = rdy[i] && srcValid[i];
            if (rdy[i]) begin
                validD[i] = srcValid[i];
            end
            if (bus.flush_mask[i]) begin
                validD[i] = 1'b0;
            end
        end
    end

    // Stage register boundary
    always_ff @(posedge clock) begin
        if (reset) begin
            validQ <= '0;
            occQ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dataQ[i] <= '0;
            end
        end else begin
            validQ <= validD;
            occQ   <= popCount(validD);
            for (int i = 0; i < DEPTH; i++) begin
                if (loadEn[i]) begin
                    dataQ[i] <= srcData[i];
                end
            end
        end
    end

    assign bus.in_ready    = rdy[0];
    assign bus.out_valid   = validQ[DEPTH-1];
    assign bus.out_data    = dataQ[DEPTH-1];
    assign bus.stage_valid = validQ;
    assign bus.occupancy   = occQ;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stage_chain
//
// Directed bench for pipeline_stage_chain (WIDTH=8, DEPTH=4, COUNTW=5).
// Each table row holds the inputs applied for one cycle, the in_ready value
// expected during that cycle, and the registered outputs expected after the
// following rising edge. Reset cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_pipeline_stage_chain;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int COUNTW = 5;

    logic clock;
    logic reset;

    pipeline_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNTW(COUNTW)) bus ();

    pipeline_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNTW(COUNTW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             inValid;
        logic [WIDTH-1:0] inData;
        logic             outReady;
        logic [DEPTH-1:0] flush;
        logic             expInReady;
        logic             expOutValid;
        logic [WIDTH-1:0] expOutData;
        logic [DEPTH-1:0] expStageValid;
        int               expOcc;
    } vec_t;

    vec_t vecs[$];
    int nCompared;
    int nMismatched;

    function automatic vec_t mk(logic iv, logic [WIDTH-1:0] id, logic ordy,
                                logic [DEPTH-1:0] fm, logic eir, logic eov,
                                logic [WIDTH-1:0] eod, logic [DEPTH-1:0] esv,
                                int eocc);
        vec_t v;
        v.inValid = iv; v.inData = id; v.outReady = ordy; v.flush = fm;
        v.expInReady = eir; v.expOutValid = eov; v.expOutData = eod;
        v.expStageValid = esv; v.expOcc = eocc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id,
                         input logic ordy, input logic [DEPTH-1:0] fm);
        bus.in_valid   = iv;
        bus.in_data    = id;
        bus.out_ready  = ordy;
        bus.flush_mask = fm;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, " out_valid"},   int'(bus.out_valid),   0);
        check({tag, " out_data"},    int'(bus.out_data),    0);
        check({tag, " stage_valid"}, int'(bus.stage_valid), 0);
        check({tag, " occupancy"},   int'(bus.occupancy),   0);
        check({tag, " in_ready"},    int'(bus.in_ready),    1);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 4'b0000);

        // ---------------- vector table ----------------
        // Stream 0x11..0x55 with out_ready=1.
        vecs.push_back(mk(1, 8'h11, 1, 4'b0000, 1, 0, 8'h00, 4'b0001, 1));
        vecs.push_back(mk(1, 8'h22, 1, 4'b0000, 1, 0, 8'h00, 4'b0011, 2));
        vecs.push_back(mk(1, 8'h33, 1, 4'b0000, 1, 0, 8'h00, 4'b0111, 3));
        vecs.push_back(mk(1, 8'h44, 1, 4'b0000, 1, 1, 8'h11, 4'b1111, 4));
        vecs.push_back(mk(1, 8'h55, 1, 4'b0000, 1, 1, 8'h22, 4'b1111, 4));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'h33, 4'b1110, 3));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'h44, 4'b1100, 2));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'h55, 4'b1000, 1));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0));
        // Back-pressure: push A0..A5 with out_ready=0; chain fills from the tail.
        vecs.push_back(mk(1, 8'hA0, 0, 4'b0000, 1, 0, 8'h00, 4'b0001, 1));
        vecs.push_back(mk(1, 8'hA1, 0, 4'b0000, 1, 0, 8'h00, 4'b0011, 2));
        vecs.push_back(mk(1, 8'hA2, 0, 4'b0000, 1, 0, 8'h00, 4'b0111, 3));
        vecs.push_back(mk(1, 8'hA3, 0, 4'b0000, 1, 1, 8'hA0, 4'b1111, 4));
        vecs.push_back(mk(1, 8'hA4, 0, 4'b0000, 0, 1, 8'hA0, 4'b1111, 4));
        vecs.push_back(mk(1, 8'hA4, 0, 4'b0000, 0, 1, 8'hA0, 4'b1111, 4));
        // Full chain with simultaneous in/out.
        vecs.push_back(mk(1, 8'hA4, 1, 4'b0000, 1, 1, 8'hA1, 4'b1111, 4));
        vecs.push_back(mk(1, 8'hA5, 1, 4'b0000, 1, 1, 8'hA2, 4'b1111, 4));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'hA3, 4'b1110, 3));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'hA4, 4'b1100, 2));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'hA5, 4'b1000, 1));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0));
        // Word accepted into stage 0 while stage 0 is flushed: accepted, discarded.
        vecs.push_back(mk(1, 8'hEE, 0, 4'b0001, 1, 0, 8'h00, 4'b0000, 0));
        // Load D,C,B,A so stage 3..0 hold DD,CC,BB,AA.
        vecs.push_back(mk(1, 8'hDD, 0, 4'b0000, 1, 0, 8'h00, 4'b0001, 1));
        vecs.push_back(mk(1, 8'hCC, 0, 4'b0000, 1, 0, 8'h00, 4'b0011, 2));
        vecs.push_back(mk(1, 8'hBB, 0, 4'b0000, 1, 0, 8'h00, 4'b0111, 3));
        vecs.push_back(mk(1, 8'hAA, 0, 4'b0000, 1, 1, 8'hDD, 4'b1111, 4));
        // Flush stages 0 and 1.
        vecs.push_back(mk(0, 8'h00, 0, 4'b0011, 0, 1, 8'hDD, 4'b1100, 2));
        vecs.push_back(mk(0, 8'h00, 0, 4'b0000, 1, 1, 8'hDD, 4'b1100, 2));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 1, 8'hCC, 4'b1000, 1));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0));

        // ---------------- reset then idle ----------------
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkIdle("reset");

        // ---------------- table ----------------
        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].inValid, vecs[r].inData, vecs[r].outReady, vecs[r].flush);
            #1;
            check($sformatf("row%0d in_ready", r), int'(bus.in_ready), int'(vecs[r].expInReady));
            @(posedge clock);
            #1;
            check($sformatf("row%0d out_valid", r), int'(bus.out_valid), int'(vecs[r].expOutValid));
            if (vecs[r].expOutValid)
                check($sformatf("row%0d out_data", r), int'(bus.out_data), int'(vecs[r].expOutData));
            check($sformatf("row%0d stage_valid", r), int'(bus.stage_valid), int'(vecs[r].expStageValid));
            check($sformatf("row%0d occupancy", r), int'(bus.occupancy), vecs[r].expOcc);
        end

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'(8'h61 + k), 1'b0, 4'b0000);
            @(posedge clock);
            #1;
        end
        check("pre-reset stage_valid", int'(bus.stage_valid), 4'b1111);
        drive(1'b1, 8'h69, 1'b1, 4'b0000);
        reset = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        @(posedge clock);  // out_ready toggled low while still checking reset state
        #1;
        // Reset cleared everything; the edge just taken (reset low, in_valid=1,
        // out_ready=0) accepted 0x69 into stage 0.
        check("post-reset stage_valid", int'(bus.stage_valid), 4'b0001);
        check("post-reset occupancy", int'(bus.occupancy), 1);
        check("post-reset out_valid", int'(bus.out_valid), 0);
        check("post-reset out_data", int'(bus.out_data), 0);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 4'b0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkIdle("reset2");

        // Stream after reset: 0x71 appears after its accept edge + 3 edges.
        for (int k = 0; k < 7; k++) begin
            drive(k < 4, 8'(8'h71 + k), 1'b1, 4'b0000);
            #1;
            check($sformatf("restream%0d in_ready", k), int'(bus.in_ready), 1);
            @(posedge clock);
            #1;
            if (k >= 3) begin
                check($sformatf("restream%0d out_valid", k), int'(bus.out_valid), 1);
                check($sformatf("restream%0d out_data", k), int'(bus.out_data), 8'h71 + k - 3);
            end else begin
                check($sformatf("restream%0d out_valid", k), int'(bus.out_valid), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
